// File: rtl/exec_ctrl_pkg.sv
// Shared encodings for the run/step/halt sequencer of the single-cycle RV32 core.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP      = 2'd2,
        ST_STEP_WAIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_RESET      = 2'd0,
        CAUSE_SWITCH     = 2'd1,
        CAUSE_BREAKPOINT = 2'd2,
        CAUSE_EBREAK     = 2'd3
    } cause_t;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    function automatic logic is_ebreak(input logic [31:0] insn);
        return (insn == EBREAK_INSN);
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Synchronizes a raw board input and filters it into a stable level plus a
// one-cycle rising-edge pulse.
module btn_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_armed;
    logic                   w_sample;
    logic                   w_sample_vld;

    assign w_sample     = r_sync[SYNC_STAGES-1];
    assign w_sample_vld = r_vld[SYNC_STAGES-1];

    // Synchronizer chain with a parallel valid chain marking real samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_vld  <= '0;
        end else begin
            r_sync[0] <= raw;
            r_vld[0]  <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
        end
    end

    // A rise only counts once a genuine low has been seen since reset, so a
    // switch already high at reset never produces a start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (w_sample_vld && !w_sample) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
            if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= w_sample;
                r_cnt   <= '0;
                r_rise  <= w_sample && r_armed;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/exec_controller.sv
// Run/step/halt sequencer: produces the core-wide enable, tracks the halt
// cause and counts retired instructions.
module exec_controller
    import exec_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic [31:0]      instruction,
    output logic             core_en,
    output logic [1:0]       ctrl_state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] retired
);
    state_t           r_state;
    state_t           w_next_state;
    cause_t           r_cause;
    cause_t           w_next_cause;
    logic             r_skip_stop;
    logic             w_next_skip;
    logic [CNT_W-1:0] r_retired;

    logic w_run_level;
    logic w_run_rise;
    logic w_step_level;
    logic w_step_rise;
    logic w_bp_match;
    logic w_ebreak_match;
    logic w_stop_hit;
    logic w_core_en;

    btn_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (run_sw),
        .level (w_run_level),
        .rise  (w_run_rise)
    );

    btn_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (step_btn),
        .level (w_step_level),
        .rise  (w_step_rise)
    );

    // Stops are detected before the offending instruction executes.
    assign w_bp_match     = bp_en && (pc == bp_addr);
    assign w_ebreak_match = is_ebreak(instruction);
    assign w_stop_hit     = (r_state == ST_RUN) && !r_skip_stop && (w_bp_match || w_ebreak_match);
    assign w_core_en      = ((r_state == ST_RUN) && !w_stop_hit) || (r_state == ST_STEP);

    // Next-state, halt-cause and skip-stop logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_cause;
        w_next_skip  = r_skip_stop;
        case (r_state)
            ST_HALT: begin
                if (w_run_rise) begin
                    w_next_state = ST_RUN;
                    w_next_skip  = 1'b1;
                end else if (w_step_rise) begin
                    w_next_state = ST_STEP;
                end else begin
                    w_next_state = ST_HALT;
                end
            end
            ST_RUN: begin
                if (w_core_en) begin
                    w_next_skip = 1'b0;
                end else begin
                    w_next_skip = r_skip_stop;
                end
                if (!w_run_level) begin
                    w_next_state = ST_HALT;
                    w_next_cause = CAUSE_SWITCH;
                end else if (w_stop_hit) begin
                    w_next_state = ST_HALT;
                    w_next_cause = w_ebreak_match ? CAUSE_EBREAK : CAUSE_BREAKPOINT;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_STEP: begin
                w_next_state = ST_STEP_WAIT;
            end
            ST_STEP_WAIT: begin
                if (!w_step_level) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_STEP_WAIT;
                end
            end
            default: begin
                w_next_state = ST_HALT;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_HALT;
            r_cause     <= CAUSE_RESET;
            r_skip_stop <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cause     <= w_next_cause;
            r_skip_stop <= w_next_skip;
        end
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_core_en) begin
            r_retired <= r_retired + CNT_W'(1);
        end else begin
            r_retired <= r_retired;
        end
    end

    assign core_en    = w_core_en;
    assign ctrl_state = r_state;
    assign halt_cause = r_cause;
    assign retired    = r_retired;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller; a second 2-bit-counter instance shares the
// stimulus and exposes counter wrap-around within a short run.
`timescale 1ns/1ps
module tb_exec_controller;
    localparam int          SYNC = 2;
    localparam int          DEB  = 4;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_sw;
    logic        step_btn;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        core_en;
    logic [1:0]  ctrl_state;
    logic [1:0]  halt_cause;
    logic [31:0] retired;
    logic        core_en_w;
    logic [1:0]  ctrl_state_w;
    logic [1:0]  halt_cause_w;
    logic [1:0]  retired_w;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          en_cnt   = 0;
    int          e0;
    logic [31:0] ebreak_pc;
    logic        en_prev;
    logic        seen_step;
    int          bounce[6] = '{1, 0, 0, 1, 1, 0};

    always #5 clk = ~clk;

    exec_controller #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc(pc), .instruction(instruction), .core_en(core_en),
        .ctrl_state(ctrl_state), .halt_cause(halt_cause), .retired(retired)
    );

    exec_controller #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc(pc), .instruction(instruction), .core_en(core_en_w),
        .ctrl_state(ctrl_state_w), .halt_cause(halt_cause_w), .retired(retired_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc          = v;
        instruction = (pc == ebreak_pc) ? EBREAK : NOP;
    endtask

    // One core cycle: the bench core advances pc when the DUT enabled it.
    task automatic cyc();
        #1;
        en_prev = core_en;
        @(posedge clk);
        @(negedge clk);
        if (en_prev) begin
            en_cnt++;
            set_pc(pc + 32'd4);
        end else begin
            set_pc(pc);
        end
        #1;
        if (ctrl_state == 2'd2 || ctrl_state == 2'd3) seen_step = 1'b1;
    endtask

    task automatic wait_state(input logic [1:0] st, input int max_cyc);
        int n;
        n = 0;
        while (ctrl_state != st && n < max_cyc) begin
            cyc();
            n++;
        end
        check_eq("wait_state", {30'd0, ctrl_state}, {30'd0, st});
    endtask

    initial begin
        rst = 1'b1; run_sw = 1'b1; step_btn = 1'b0; bp_en = 1'b0; bp_addr = 32'd0;
        ebreak_pc = 32'hFFFF_FFF0; seen_step = 1'b0;
        set_pc(32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_state", {30'd0, ctrl_state}, 32'd0);
        check_eq("rst_core_en", {31'd0, core_en}, 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_cause", {30'd0, halt_cause}, 32'd0);
        rst = 1'b0;
        repeat (12) cyc();
        check_eq("no_run_high_at_reset", {30'd0, ctrl_state}, 32'd0);
        check_eq("no_retire_high_at_reset", retired, 32'd0);

        // Clean run: switch edge, latency, per-cycle retirement, switch halt
        run_sw = 1'b0;
        repeat (8) cyc();
        run_sw = 1'b1;
        repeat (SYNC + DEB) cyc();
        check_eq("run_not_early", {30'd0, ctrl_state}, 32'd0);
        cyc();
        check_eq("run_latency", {30'd0, ctrl_state}, 32'd1);
        check_eq("run_core_en", {31'd0, core_en}, 32'd1);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            check_eq("retire_inc", retired, i);
            check_eq("retire_wrap_narrow", {30'd0, retired_w}, i % 4);
        end
        run_sw = 1'b0;
        repeat (10) cyc();
        check_eq("sw_halt_state", {30'd0, ctrl_state}, 32'd0);
        check_eq("sw_halt_cause", {30'd0, halt_cause}, 32'd1);
        check_eq("sw_halt_retired", retired, 32'd17);

        // Breakpoint at 0x10, then resume past it
        rst = 1'b1;
        #1;
        rst = 1'b0;
        en_cnt = 0;
        set_pc(32'd0);
        bp_en = 1'b1; bp_addr = 32'h0000_0010;
        repeat (4) cyc();
        run_sw = 1'b1;
        wait_state(2'd1, 20);
        repeat (4) cyc();
        check_eq("bp_pc", pc, 32'h10);
        check_eq("bp_core_en_off", {31'd0, core_en}, 32'd0);
        cyc();
        check_eq("bp_state", {30'd0, ctrl_state}, 32'd0);
        check_eq("bp_cause", {30'd0, halt_cause}, 32'd2);
        check_eq("bp_retired", retired, 32'd4);
        run_sw = 1'b0;
        repeat (8) cyc();
        check_eq("bp_halt_hold", {30'd0, ctrl_state}, 32'd0);
        run_sw = 1'b1;
        wait_state(2'd1, 20);
        check_eq("resume_bp_en", {31'd0, core_en}, 32'd1);
        cyc();
        check_eq("resume_pc", pc, 32'h14);
        check_eq("resume_state", {30'd0, ctrl_state}, 32'd1);
        check_eq("resume_retired", retired, 32'd5);

        // EBREAK at 0x20 (breakpoint also matches there; EBREAK wins)
        bp_addr = 32'h0000_0020; ebreak_pc = 32'h0000_0020;
        repeat (3) cyc();
        check_eq("ebreak_pc", pc, 32'h20);
        check_eq("ebreak_core_en_off", {31'd0, core_en}, 32'd0);
        cyc();
        check_eq("ebreak_state", {30'd0, ctrl_state}, 32'd0);
        check_eq("ebreak_cause", {30'd0, halt_cause}, 32'd3);
        check_eq("ebreak_retired", retired, 32'd8);

        // Bouncy single step over the EBREAK
        e0 = en_cnt;
        foreach (bounce[i]) begin
            step_btn = bounce[i][0];
            cyc();
        end
        check_eq("bounce_no_step", {30'd0, ctrl_state}, 32'd0);
        step_btn = 1'b1;
        repeat (10) cyc();
        check_eq("step_wait_state", {30'd0, ctrl_state}, 32'd3);
        check_eq("step_cause_held", {30'd0, halt_cause}, 32'd3);
        check_eq("step_one_en", en_cnt - e0, 32'd1);
        check_eq("step_retired", retired, 32'd9);
        check_eq("step_pc", pc, 32'h24);
        step_btn = 1'b0;
        repeat (4) cyc();
        check_eq("step_wait_hold", {30'd0, ctrl_state}, 32'd3);
        repeat (4) cyc();
        check_eq("step_release", {30'd0, ctrl_state}, 32'd0);
        check_eq("step_still_one_en", en_cnt - e0, 32'd1);

        // Step button while running has no effect
        ebreak_pc = 32'hFFFF_FFF0; bp_en = 1'b0;
        run_sw = 1'b0;
        repeat (8) cyc();
        run_sw = 1'b1;
        wait_state(2'd1, 20);
        seen_step = 1'b0;
        step_btn = 1'b1;
        repeat (10) cyc();
        step_btn = 1'b0;
        repeat (10) cyc();
        check_eq("run_step_ignored_state", {30'd0, ctrl_state}, 32'd1);
        check_eq("run_step_never_seen", {31'd0, seen_step}, 32'd0);
        check_eq("run_step_retired", retired, 32'd29);

        // Asynchronous reset mid-run with the narrow counter one short of wrap
        cyc();
        check_eq("pre_rst_retired", retired, 32'd30);
        check_eq("pre_rst_narrow", {30'd0, retired_w}, 32'd2);
        rst = 1'b1;
        #1;
        check_eq("midrun_rst_state", {30'd0, ctrl_state}, 32'd0);
        check_eq("midrun_rst_core_en", {31'd0, core_en}, 32'd0);
        check_eq("midrun_rst_retired", retired, 32'd0);
        check_eq("midrun_rst_narrow", {30'd0, retired_w}, 32'd0);
        check_eq("midrun_rst_cause", {30'd0, halt_cause}, 32'd0);
        #1;
        rst = 1'b0;

        // Narrow counter wrap from 3 to 0 to 1
        en_cnt = 0;
        set_pc(32'd0);
        run_sw = 1'b0;
        repeat (8) cyc();
        run_sw = 1'b1;
        wait_state(2'd1, 20);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check_eq("wrap_narrow", {30'd0, retired_w}, i % 4);
            check_eq("wrap_wide", retired, i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
- Run/step/halt sequencer for the single-cycle RV32 core.
- Generates the core-wide enable `core_en`, which gates the PC update, register-file write and data-memory write.
- Halts on a PC breakpoint, on EBREAK or on the run switch. Supports single-step from a debounced push button.
- Counts retired instructions and reports the halt cause for the 7-segment display path.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on each asynchronous board input.
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized cycles required before a debounced input changes (5 ms at 50 MHz). The bench overrides it to 4.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, same clock as the core.
- rst  in  1  asynchronous reset, active-high.
- run_sw  in  1  board switch. High requests RUN, low requests HALT.
- step_btn  in  1  board push button, raw and bouncy.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  32  breakpoint PC.
- pc  in  32  current core PC.
- instruction  in  32  current fetched instruction.
- core_en  out  1  core state-update enable. The instruction at `pc` retires on a clk edge where this is 1.
- ctrl_state  out  2  0=HALT, 1=RUN, 2=STEP, 3=STEP_WAIT.
- halt_cause  out  2  0=reset, 1=switch, 2=breakpoint, 3=ebreak.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (asynchronous, immediate):
  - state=HALT, core_en=0, halt_cause=0, retired=0.
  - All synchronizer and debounce registers cleared.
  - skip_stop=0.
  - Applies mid-RUN or mid-STEP with no partial retirement.
- Input conditioning:
  - `run_sw` and `step_btn` each pass through SYNC_STAGES flops, then the debouncer.
  - The debounced value takes the new level only after DEBOUNCE_CYCLES consecutive equal synchronized samples. Any differing sample restarts the count.
  - `run_rise` and `step_rise` are one-cycle pulses on a debounced 0->1 transition.
- `stop_hit` is combinational: state==RUN && !skip_stop && ((bp_en && pc==bp_addr) || instruction==32'h00100073).
- `core_en` is combinational: (state==RUN && !stop_hit) || state==STEP. A stop therefore takes effect before the offending instruction executes.
- HALT:
  - If run_rise, go to RUN and set skip_stop=1.
  - Else if step_rise, go to STEP.
  - If both pulse in the same cycle, RUN wins and the step is dropped.
  - A `run_sw` level already high at reset does not start the core; a rising edge is required.
- RUN:
  - If debounced run_sw==0, go to HALT with cause=1. This has priority over stop_hit in the same cycle.
  - Else if stop_hit, go to HALT with cause=2 for a breakpoint or 3 for EBREAK. If both match, cause=3.
  - skip_stop clears after the first retiring cycle. Resuming from a breakpoint or EBREAK address therefore executes that instruction once instead of re-halting.
  - step_rise is ignored.
- STEP:
  - Exactly one cycle with core_en=1, then go to STEP_WAIT.
  - Breakpoint and EBREAK are not checked. EBREAK retires as a no-op.
- STEP_WAIT: wait for debounced step_btn==0, then go to HALT. halt_cause is unchanged.
- retired:
  - Increments by 1 on every clk edge where core_en=1.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- halt_cause updates only on RUN->HALT transitions. It holds through STEP and STEP_WAIT.

Decomposition:
- Package `exec_ctrl_pkg` holds:
  - the state encodings;
  - the halt_cause codes;
  - EBREAK_INSN = 32'h00100073.
- Sub-module `btn_debouncer`:
  - parameters SYNC_STAGES and DEBOUNCE_CYCLES;
  - ports clk, rst, raw, level, rise;
  - instantiated twice, once for run_sw and once for step_btn.
- exec_controller holds the FSM, skip_stop, the stop comparator and the counter.

Test Plan:
- Reset while run_sw=1 -> state=0, core_en=0, retired=0. No RUN without a 0->1 edge.
- run_sw 0->1, held stable, bp_en=0, 10 instructions with no EBREAK:
  - ctrl_state=1 exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after the toggle;
  - retired increments by 1 every cycle;
  - run_sw 1->0 -> halt_cause=1.
- bp_en=1, bp_addr=32'h0000_0010, PC sequence 0,4,8,C,10:
  - halts with pc=32'h10, halt_cause=2, retired=4;
  - run_sw toggle -> the instruction at 0x10 retires, and execution continues to 0x14 without re-halting.
- instruction=32'h00100073 at pc 0x20 while RUN -> core_en=0 in that cycle, halt_cause=3.
- Bouncy step_btn: pulses of 1-2 cycles, then stable high for 10 cycles, then low:
  - exactly one core_en=1 cycle and retired+1;
  - STEP_WAIT is held until release;
  - step_btn during RUN has no effect.
- Assert rst mid-RUN with retired=0xFFFF_FFFE -> immediate HALT, retired=0.
- Separately, preset and run 3 instructions -> retired wraps FFFF_FFFF->0->1.
